// File: rtl/adc_channel_scheduler_if.sv
// SAR-side bundle: analog-mux select and the start/done/result handshake
// between the channel scheduler (master) and the shared SAR core (slave).
interface adc_channel_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
);
    localparam int CW = $clog2(NUM_CH);

    logic [CW-1:0]    mux_sel;
    logic             sar_start;
    logic             sar_done;
    logic [WIDTH-1:0] sar_result;

    modport master (
        output mux_sel,
        output sar_start,
        input  sar_done,
        input  sar_result
    );

    modport slave (
        input  mux_sel,
        input  sar_start,
        output sar_done,
        output sar_result
    );
endinterface

// File: rtl/adc_channel_scheduler.sv
// Multi-channel SAR conversion scheduler: round-robin scan over masked-in
// mux channels, one-shot pre-emption, mux settle delay, conversion timeout
// with sticky per-channel error flags, and a per-channel result bank.
module adc_channel_scheduler #(
    parameter int NUM_CH            = 4,
    parameter int WIDTH             = 8,
    parameter int MUX_SETTLE_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES    = 2_000_000,
    localparam int CW               = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic                  oneshot_req,
    input  logic [CW-1:0]         oneshot_ch,
    input  logic                  err_clr,
    input  logic [CW-1:0]         rd_ch,
    adc_channel_scheduler_if.master sar,
    output logic                  busy,
    output logic                  oneshot_pending,
    output logic                  result_valid,
    output logic [CW-1:0]         result_ch,
    output logic [WIDTH-1:0]      result_data,
    output logic [WIDTH-1:0]      rd_data,
    output logic [NUM_CH-1:0]     ch_err
);

    // One shared counter covers both the settle interval and the timeout.
    localparam int CNT_MAX = (MUX_SETTLE_CYCLES > TIMEOUT_CYCLES) ? MUX_SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(MUX_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        START,
        WAIT,
        STORE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]     mux_sel_q, mux_sel_d;
    logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              os_pending_q, os_pending_d;
    logic [CW-1:0]     os_ch_q, os_ch_d;
    logic [CW-1:0]     result_ch_q, result_ch_d;
    logic [WIDTH-1:0]  result_data_q, result_data_d;
    logic [NUM_CH-1:0] ch_err_q, ch_err_d;
    logic [WIDTH-1:0]  ch_data_q [NUM_CH];
    logic [WIDTH-1:0]  ch_data_d [NUM_CH];
    logic              timeout_hit;
    logic [CW:0]       rr_pick;
    logic              rr_found;
    logic [CW-1:0]     rr_next;

    // First masked-in channel strictly after ptr, wrapping; MSB flags "found".
    function automatic logic [CW:0] first_after(input logic [CW-1:0] ptr,
                                                input logic [NUM_CH-1:0] mask);
        logic [CW:0] pick;
        int          idx;
        pick = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (!pick[CW] && mask[idx[CW-1:0]]) begin
                pick = {1'b1, idx[CW-1:0]};
            end
        end
        return pick;
    endfunction

    assign rr_pick  = first_after(rr_ptr_q, ch_mask);
    assign rr_found = rr_pick[CW];
    assign rr_next  = rr_pick[CW-1:0];

    // Next-state, channel choice, counters and result capture.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mux_sel_d     = mux_sel_q;
        rr_ptr_d      = rr_ptr_q;
        os_pending_d  = os_pending_q;
        os_ch_d       = os_ch_q;
        result_ch_d   = result_ch_q;
        result_data_d = result_data_q;
        timeout_hit   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data_d[i] = ch_data_q[i];
        end

        // First request wins; later requests are dropped while one is pending.
        if (oneshot_req && !os_pending_q) begin
            os_pending_d = 1'b1;
            os_ch_d      = oneshot_ch;
        end

        case (state_q)
            IDLE: begin
                if (os_pending_q || (enable && |ch_mask)) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                cnt_d = '0;
                if (os_pending_q) begin
                    // One-shot ignores the mask and leaves the scan pointer alone.
                    mux_sel_d    = os_ch_q;
                    os_pending_d = 1'b0;
                    state_d      = SETTLE;
                end else if (rr_found) begin
                    mux_sel_d = rr_next;
                    rr_ptr_d  = rr_next;
                    state_d   = SETTLE;
                end else begin
                    // Mask went empty between IDLE and SELECT: nothing to do.
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (sar.sar_done) begin
                    ch_data_d[mux_sel_q] = sar.sar_result;
                    result_data_d        = sar.sar_result;
                    result_ch_d          = mux_sel_q;
                    state_d              = STORE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STORE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky error flags: a timeout in the same cycle as err_clr keeps the bit.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_err
        assign ch_err_d[gi] = (timeout_hit && (mux_sel_q == CW'(gi))) ||
                              (ch_err_q[gi] && !err_clr);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mux_sel_q     <= '0;
            rr_ptr_q      <= CW'(NUM_CH - 1);
            os_pending_q  <= 1'b0;
            os_ch_q       <= '0;
            result_ch_q   <= '0;
            result_data_q <= '0;
            ch_err_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_data_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mux_sel_q     <= mux_sel_d;
            rr_ptr_q      <= rr_ptr_d;
            os_pending_q  <= os_pending_d;
            os_ch_q       <= os_ch_d;
            result_ch_q   <= result_ch_d;
            result_data_q <= result_data_d;
            ch_err_q      <= ch_err_d;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_data_q[i] <= ch_data_d[i];
            end
        end
    end

    assign sar.mux_sel      = mux_sel_q;
    assign sar.sar_start    = (state_q == START);
    assign busy             = (state_q != IDLE);
    assign result_valid     = (state_q == STORE);
    assign oneshot_pending  = os_pending_q;
    assign result_ch        = result_ch_q;
    assign result_data      = result_data_q;
    assign ch_err           = ch_err_q;
    assign rd_data          = ch_data_q[rd_ch];

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Self-checking bench for adc_channel_scheduler: directed sequences for scan
// order, settle timing, one-shot pre-emption, timeout/err_clr, stop and
// reset, then a randomized run checked against a transaction-level model.
module tb_adc_channel_scheduler;
    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int M      = 4;
    localparam int T      = 50;
    localparam int SAR_LAT = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] ch_mask = 4'b0;
    logic       oneshot_req = 1'b0;
    logic [1:0] oneshot_ch = 2'd0;
    logic       err_clr = 1'b0;
    logic [1:0] rd_ch = 2'd0;
    logic       busy, oneshot_pending, result_valid;
    logic [1:0] result_ch;
    logic [7:0] result_data, rd_data;
    logic [3:0] ch_err;

    adc_channel_scheduler_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) sar_if();

    adc_channel_scheduler #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH),
        .MUX_SETTLE_CYCLES(M), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .oneshot_req(oneshot_req), .oneshot_ch(oneshot_ch), .err_clr(err_clr),
        .rd_ch(rd_ch), .sar(sar_if), .busy(busy), .oneshot_pending(oneshot_pending),
        .result_valid(result_valid), .result_ch(result_ch), .result_data(result_data),
        .rd_data(rd_data), .ch_err(ch_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bound_fail(input string name, input int maxc);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event not seen within %0d cycles, got none, expected one", name, maxc);
    endtask

    task automatic wait_valid(input int maxc, input string name);
        int k = 0;
        do begin tick(); k++; end while (!result_valid && k < maxc);
        if (!result_valid) bound_fail(name, maxc);
    endtask

    task automatic wait_start(input int maxc, input string name);
        int k = 0;
        do begin tick(); k++; end while (!sar_if.sar_start && k < maxc);
        if (!sar_if.sar_start) bound_fail(name, maxc);
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int k = 0;
        while ((busy || oneshot_pending) && k < maxc) begin tick(); k++; end
        if (busy || oneshot_pending) bound_fail(name, maxc);
    endtask

    task automatic apply_reset();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mux_sel"}, int'(sar_if.mux_sel), 0);
        check({tag, "_sar_start"}, int'(sar_if.sar_start), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_pending"}, int'(oneshot_pending), 0);
        check({tag, "_result_valid"}, int'(result_valid), 0);
        check({tag, "_result_ch"}, int'(result_ch), 0);
        check({tag, "_result_data"}, int'(result_data), 0);
        check({tag, "_ch_err"}, int'(ch_err), 0);
        for (int i = 0; i < NUM_CH; i++) begin
            rd_ch = 2'(i);
            #1;
            check({tag, "_rd_data"}, int'(rd_data), 0);
        end
    endtask

    // SAR core model: answers 0x10+ch SAR_LAT cycles after start unless hung.
    logic [3:0] hang = 4'b0;
    bit         m_pend = 0;
    bit         m_drove = 0;
    int         m_left = 0;
    int         m_ch = 0;
    initial begin
        sar_if.sar_done   = 1'b0;
        sar_if.sar_result = 8'h00;
    end
    always @(negedge clk) begin
        if (m_drove) begin
            sar_if.sar_done = 1'b0;
            m_drove = 0;
        end
        if (m_pend) begin
            m_left--;
            if (m_left == 0) begin
                sar_if.sar_done   = 1'b1;
                sar_if.sar_result = 8'(16 + m_ch);
                m_drove = 1;
                m_pend  = 0;
            end
        end
        if (sar_if.sar_start && !hang[sar_if.mux_sel]) begin
            m_pend = 1;
            m_left = SAR_LAT;
            m_ch   = int'(sar_if.mux_sel);
        end
    end

    // Transaction-level reference model for the randomized run.
    typedef struct { int c; int ch; } os_ev_t;
    typedef struct { int ch; int s; } exp_t;
    bit         rand_on = 0;
    logic [3:0] mask_hist [4096];
    os_ev_t     osq[$];
    exp_t       expq[$];
    int         m_rr = 3;
    bit         m_os_pend = 0;
    int         m_os_ch = 0;
    int         m_data [4];

    function automatic int next_scan(input int ptr, input logic [3:0] m);
        int j;
        for (int i = 1; i <= NUM_CH; i++) begin
            j = (ptr + i) % NUM_CH;
            if (m[j[1:0]]) return j;
        end
        return -1;
    endfunction

    // Record the inputs seen at each active edge (cycle that edge closes).
    always @(posedge clk) begin
        if (rand_on) begin
            mask_hist[cyc % 4096] = ch_mask;
            if (oneshot_req) osq.push_back('{c: cyc, ch: int'(oneshot_ch)});
        end
        cyc++;
    end

    // Predict each conversion's channel from the selection rules; check results.
    always @(negedge clk) begin
        if (rand_on) begin
            if (sar_if.sar_start) begin
                int t;
                int exp_ch;
                bit used;
                os_ev_t r;
                exp_t e;
                t = cyc - 1 - M;
                while (osq.size() > 0 && osq[0].c < t) begin
                    r = osq.pop_front();
                    if (!m_os_pend) begin m_os_pend = 1; m_os_ch = r.ch; end
                end
                used = m_os_pend;
                if (used) begin
                    exp_ch = m_os_ch;
                end else begin
                    exp_ch = next_scan(m_rr, mask_hist[t % 4096]);
                    m_rr = exp_ch;
                end
                while (osq.size() > 0 && osq[0].c == t) begin
                    r = osq.pop_front();
                    if (!m_os_pend) begin m_os_pend = 1; m_os_ch = r.ch; end
                end
                if (used) m_os_pend = 0;
                check("rand_start_ch", int'(sar_if.mux_sel), exp_ch);
                e.ch = exp_ch;
                e.s  = cyc;
                expq.push_back(e);
            end
            if (result_valid) begin
                exp_t e;
                if (expq.size() == 0) begin
                    bound_fail("rand_unexpected_result", 0);
                end else begin
                    e = expq.pop_front();
                    check("rand_result_ch", int'(result_ch), e.ch);
                    check("rand_result_data", int'(result_data), 16 + e.ch);
                    check("rand_result_latency", cyc - e.s, SAR_LAT + 1);
                    m_data[e.ch] = 16 + e.ch;
                end
            end
        end
    end

    typedef struct { logic [1:0] rd_ch; logic [7:0] exp_rd; } rd_vec_t;

    initial begin
        rd_vec_t rd_vecs [4];
        int scan_exp [6];
        int os_exp [5];
        int t_sel, t_mux, t_start, n_start, t_valid, t_idle, t_err, saw_valid;

        rd_vecs[0] = '{rd_ch: 2'd0, exp_rd: 8'h10};
        rd_vecs[1] = '{rd_ch: 2'd1, exp_rd: 8'h11};
        rd_vecs[2] = '{rd_ch: 2'd2, exp_rd: 8'h00};
        rd_vecs[3] = '{rd_ch: 2'd3, exp_rd: 8'h13};
        scan_exp = '{0, 1, 3, 0, 1, 3};
        os_exp   = '{0, 2, 1, 3, 0};

        // Reset state
        apply_reset();
        check_reset_outputs("reset");

        // Scan order with mask 1011
        ch_mask = 4'b1011;
        enable  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_valid(100, "scan_valid");
            check("scan_result_ch", int'(result_ch), scan_exp[i]);
            check("scan_result_data", int'(result_data), 16 + scan_exp[i]);
        end
        enable = 1'b0;
        wait_idle(100, "scan_idle");
        for (int i = 0; i < 4; i++) begin
            rd_ch = rd_vecs[i].rd_ch;
            #1;
            check("scan_rd_data", int'(rd_data), int'(rd_vecs[i].exp_rd));
        end

        // Settle timing, plus enable dropped during WAIT
        apply_reset();
        ch_mask = 4'b0100;
        enable  = 1'b1;
        t_sel = -1; t_mux = -1; t_start = -1; n_start = 0; t_valid = -1; t_idle = -1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (busy && t_sel < 0) t_sel = k;
            if (sar_if.mux_sel == 2'd2 && t_mux < 0) t_mux = k;
            if (sar_if.sar_start) begin
                n_start++;
                if (t_start < 0) t_start = k;
            end
            if (result_valid && t_valid < 0) t_valid = k;
            if (t_valid >= 0 && !busy && t_idle < 0) t_idle = k;
            if (t_sel >= 0 && k == t_sel + 10) enable = 1'b0;
        end
        check("settle_mux_latency", t_mux - t_sel, 1);
        check("settle_start_latency", t_start - t_sel, M + 1);
        check("settle_start_count", n_start, 1);
        check("settle_valid_latency", t_valid - t_start, SAR_LAT + 1);
        check("stop_busy_low", t_idle - t_valid, 1);
        check("stop_result_ch", int'(result_ch), 2);
        check("stop_result_data", int'(result_data), 8'h12);

        // sar_done while idle is ignored
        sar_if.sar_result = 8'hAA;
        sar_if.sar_done   = 1'b1;
        tick();
        sar_if.sar_done = 1'b0;
        check("stray_done_valid", int'(result_valid), 0);
        check("stray_done_busy", int'(busy), 0);
        rd_ch = 2'd2;
        #1;
        check("stray_done_rd_data", int'(rd_data), 8'h12);

        // One-shot pre-emption, second request dropped
        apply_reset();
        ch_mask = 4'b1011;
        enable  = 1'b1;
        wait_start(60, "os_first_start");
        check("os_inflight_ch", int'(sar_if.mux_sel), 0);
        tick();
        tick();
        oneshot_ch  = 2'd2;
        oneshot_req = 1'b1;
        tick();
        oneshot_req = 1'b0;
        check("os_pending_rise", int'(oneshot_pending), 1);
        tick();
        tick();
        oneshot_ch  = 2'd3;
        oneshot_req = 1'b1;
        tick();
        oneshot_req = 1'b0;
        check("os_pending_held", int'(oneshot_pending), 1);
        for (int i = 0; i < 5; i++) begin
            wait_valid(100, "os_valid");
            check("os_result_ch", int'(result_ch), os_exp[i]);
            if (i == 1) check("os_pending_cleared", int'(oneshot_pending), 0);
        end
        enable = 1'b0;
        wait_idle(100, "os_idle");

        // Timeout on ch1, err_clr, and timeout-vs-clear precedence
        apply_reset();
        hang    = 4'b0010;
        ch_mask = 4'b1011;
        enable  = 1'b1;
        wait_valid(100, "to_first_valid");
        check("to_first_ch", int'(result_ch), 0);
        wait_start(60, "to_start");
        check("to_start_ch", int'(sar_if.mux_sel), 1);
        t_err = -1;
        saw_valid = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (ch_err == 4'b0010 && t_err < 0) t_err = k;
            if (result_valid) saw_valid = 1;
        end
        check("to_err_latency", t_err, T + 1);
        check("to_no_result_valid", saw_valid, 0);
        wait_valid(100, "to_next_valid");
        check("to_scan_continues_ch", int'(result_ch), 3);
        check("to_err_sticky", int'(ch_err), 4'b0010);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", int'(ch_err), 0);
        wait_valid(100, "to_round2_valid");
        check("to_round2_ch", int'(result_ch), 0);
        wait_start(60, "to_round2_start");
        check("to_round2_start_ch", int'(sar_if.mux_sel), 1);
        repeat (T) tick();
        check("to_not_early", int'(ch_err), 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr_vs_timeout", int'(ch_err), 4'b0010);
        enable = 1'b0;
        wait_idle(100, "to_idle");
        hang = 4'b0000;

        // Reset during SETTLE
        ch_mask = 4'b0001;
        enable  = 1'b1;
        begin
            int k = 0;
            while (!busy && k < 20) begin tick(); k++; end
            if (!busy) bound_fail("rst_select", 20);
        end
        tick();
        tick();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        reset = 1'b0;
        check_reset_outputs("midrst");
        n_start = 0;
        saw_valid = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (sar_if.sar_start) n_start++;
            if (result_valid) saw_valid = 1;
        end
        check("midrst_no_start", n_start, 0);
        check("midrst_no_valid", saw_valid, 0);

        // Randomized run against the reference model
        apply_reset();
        osq.delete();
        expq.delete();
        m_rr = 3;
        m_os_pend = 0;
        for (int i = 0; i < 4; i++) m_data[i] = 0;
        ch_mask = 4'($urandom_range(15, 1));
        enable  = 1'b1;
        rand_on = 1;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if ($urandom_range(99) == 0) enable = ~enable;
            if ($urandom_range(199) == 0) ch_mask = 4'($urandom_range(15, 1));
            oneshot_req = ($urandom_range(39) == 0);
            oneshot_ch  = 2'($urandom_range(3));
            err_clr     = ($urandom_range(99) == 0);
        end
        oneshot_req = 1'b0;
        err_clr     = 1'b0;
        enable      = 1'b0;
        tick();
        wait_idle(200, "rand_drain");
        tick();
        rand_on = 0;
        check("rand_queue_empty", expq.size(), 0);
        check("rand_ch_err", int'(ch_err), 0);
        for (int i = 0; i < 4; i++) begin
            rd_ch = 2'(i);
            #1;
            check("rand_rd_data", int'(rd_data), m_data[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adc_channel_scheduler.md
# adc_channel_scheduler

Sequences SAR conversions across several analog-mux channels that share one R2R DAC, comparator and `sar_adc` core. It drives the analog-mux select and waits a fixed mux-settle interval. It then issues a one-cycle `start` to the SAR core and stores each `adc_result` in a per-channel result register. It sits between the board-level mux pins and the SAR section of the R2R subsystem, replacing its free-running auto-start logic. Round-robin scanning is the default, and a one-shot request can pre-empt the next slot.

## Interface
Parameters:
- `NUM_CH`, default 4: number of mux channels (≥2). `CW = $clog2(NUM_CH)`.
- `WIDTH`, default 8: conversion result width.
- `MUX_SETTLE_CYCLES`, default 1000: clocks between a mux change and `sar_start` (≥1).
- `TIMEOUT_CYCLES`, default 2_000_000: maximum clocks spent waiting for `sar_done` (≥2).

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  round-robin scanning enabled
- `ch_mask`  in  NUM_CH  channels included in the scan
- `oneshot_req`  in  1  single-cycle pulse requesting one conversion of `oneshot_ch`
- `oneshot_ch`  in  CW  channel for the one-shot conversion
- `err_clr`  in  1  pulse that clears all `ch_err` bits
- `rd_ch`  in  CW  readback channel select
- `sar_done`  in  1  `conversion_done` pulse from the SAR core
- `sar_result`  in  WIDTH  `adc_result` from the SAR core
- `mux_sel`  out  CW  analog-mux select (registered)
- `sar_start`  out  1  one-cycle start pulse to the SAR core
- `busy`  out  1  high in every state except IDLE
- `oneshot_pending`  out  1  a one-shot request is latched and not yet started
- `result_valid`  out  1  one-cycle pulse when a result is stored
- `result_ch`  out  CW  channel of the last stored result
- `result_data`  out  WIDTH  value of the last stored result
- `rd_data`  out  WIDTH  stored result of channel `rd_ch` (combinational read)
- `ch_err`  out  NUM_CH  sticky per-channel timeout flags

## Operation
- States: IDLE, SELECT, SETTLE, START, WAIT, STORE.
- IDLE → SELECT when `oneshot_pending`, or when `enable && |ch_mask`. Otherwise the block stays in IDLE.
- SELECT (1 cycle) chooses the channel:
  - If `oneshot_pending`, the block takes `os_ch` and clears `oneshot_pending`. `ch_mask` is ignored for the one-shot.
  - Otherwise the block takes the first masked-in channel after `rr_ptr` (wrap-around search) and sets `rr_ptr` to it.
  - One-shot service does not move `rr_ptr`.
- In SELECT, `mux_sel` is loaded with the chosen channel.
- SETTLE counts `MUX_SETTLE_CYCLES`, then goes to START.
- START asserts `sar_start` for exactly one cycle, then goes to WAIT.
- WAIT ends on either of two events:
  - `sar_done`: capture `sar_result` into `ch_data[ch]`, `result_data` and `result_ch`, then go to STORE.
  - `TIMEOUT_CYCLES` elapse without `sar_done`: set `ch_err[ch]`, store no data, then go to IDLE.
- STORE asserts `result_valid` for 1 cycle, then goes to IDLE.
- One-shot latch:
  - `oneshot_req` while `oneshot_pending=0` sets the pending flag and latches `os_ch = oneshot_ch`.
  - A request while already pending is ignored; the first request wins.
- `enable` deasserting mid-conversion does not abort. The current conversion completes and stores its result, then the block idles.
- `ch_mask` is sampled only in SELECT; changing it mid-conversion does not affect the channel in flight.
- `sar_done` outside WAIT is ignored.
- `ch_err` precedence: a timeout set and `err_clr` in the same cycle leave the bit set.

## Timing
- Reset values:
  - Outputs: `mux_sel=0`, `sar_start=0`, `busy=0`, `oneshot_pending=0`, `result_valid=0`, `result_ch=0`, `result_data=0`, `ch_err=0`.
  - Internal: all `ch_data=0` (so `rd_data=0`), `rr_ptr=NUM_CH-1` so the first scanned channel is 0, state IDLE.
- Reset mid-operation returns every register to its reset value on the next edge. No `sar_start` or `result_valid` follows.
- Cycle-level sequence, with SELECT in cycle t:
  - `mux_sel` is valid from t+1.
  - `sar_start` is high in cycle t+1+MUX_SETTLE_CYCLES only.
  - If `sar_done` is sampled in cycle d, `ch_data`, `result_data` and `result_ch` update at d+1 and `result_valid` is high in d+1.
  - Back in IDLE at d+2; the next SELECT is no earlier than d+3.
- Timeout: if `sar_done` never arrives after `sar_start` in cycle s, `ch_err[ch]` is set at edge s+1+TIMEOUT_CYCLES.
- `oneshot_pending` rises the cycle after `oneshot_req`.

## Test plan
Bench parameters: `NUM_CH=4`, `MUX_SETTLE_CYCLES=4`, `TIMEOUT_CYCLES=50`. A SAR model returns `0x10+ch` 20 cycles after `sar_start`.
- Scan order: `enable=1`, `ch_mask=4'b1011` → `result_ch` sequence 0,1,3,0,1,3; `rd_data` is 0x10, 0x11, 0x13 for `rd_ch` 0, 1, 3, and 0x00 for `rd_ch` 2.
- Settle timing: SELECT at cycle t → `mux_sel` changes at t+1, single `sar_start` at t+5, `result_valid` 21 cycles after `sar_start`.
- One-shot pre-emption: scanning ch0, `oneshot_req` with `oneshot_ch=2` (masked out), a second request with `oneshot_ch=3` 3 cycles later → next conversion is ch2 only, then the scan resumes at ch1; the ch3 request is dropped.
- Timeout and error clear: the SAR model never returns `done` on ch1 → `ch_err=4'b0010` 51 cycles after `sar_start`, no `result_valid`, the scan continues to ch3; `err_clr` → `ch_err=0`.
- Stop and reset: `enable` dropped during WAIT → the result is still stored, then `busy=0`. Reset asserted during SETTLE → all outputs return to reset values and no `sar_start` follows.
